// File: rtl/aes_cbc_decipher_ctrl.sv
// aes_cbc_decipher_ctrl: CBC chaining stage around aes_decipher_block, valid/ready in and out.
module aes_cbc_decipher_ctrl #(
  parameter bit CHAIN_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init_iv,
  input  logic [127:0] iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic         dec_next,
  output logic [127:0] dec_block,
  input  logic         dec_ready,
  input  logic [127:0] dec_new_block
);
  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;
  state_t       state;
  logic [127:0] ct_reg, chain_reg;
  logic         seen_low;
  assign in_ready  = !busy && !init_iv;
  assign dec_block = ct_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ct_reg    <= '0;
      chain_reg <= '0;
      out_block <= '0;
      seen_low  <= 1'b0;
      dec_next  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      dec_next <= 1'b0;
      case (state)
        IDLE: begin
          if (init_iv) chain_reg <= iv;
          else if (in_valid) begin
            ct_reg   <= in_block;
            dec_next <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          seen_low <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          // a ready seen before the decipher has dropped it belongs to the previous block
          if (!dec_ready) seen_low <= 1'b1;
          if (dec_ready && seen_low) begin
            out_block <= dec_new_block ^ (CHAIN_EN ? chain_reg : '0);
            chain_reg <= ct_reg;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_cbc_decipher_ctrl.sv
// tb_aes_cbc_decipher_ctrl: CBC (instance 0) and ECB (instance 1) controllers driving a
// behavioural decipher stand-in, checked against a block-level chaining model.
module tb_aes_cbc_decipher_ctrl;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         init_iv [2];
  logic [127:0] iv [2];
  logic         in_valid [2];
  logic         in_ready [2];
  logic [127:0] in_block [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] out_block [2];
  logic         busy [2];
  logic         dec_next [2];
  logic [127:0] dec_block [2];
  logic         dec_ready [2];
  logic [127:0] dec_new_block [2];
  int           m_lat [2];
  int           m_early [2];
  int           npulse [2];
  logic [127:0] ref_chain [2];
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  // Known AES-128 decryptions under key 2b7e1516...; other blocks use a stand-in bijection.
  function automatic logic [127:0] aes_dec(input logic [127:0] c);
    case (c)
      128'h7649abac8119b246cee98e9b12e9197d: return 128'h6bc0bce12a459991e134741a7f9e1925;
      128'h5086cb9b507219ee95db113a917678b2: return 128'hd86421fb9f1a1eda505ee1375746972c;
      128'h3ad77bb40d7a3660a89ecaf32466ef97: return 128'h6bc1bee22e409f96e93d7e117393172a;
      default: return {c[63:0], c[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic         pend, run;
    int           hold, cnt;
    logic [127:0] m_ct;
    aes_cbc_decipher_ctrl #(.CHAIN_EN(g == 0)) dut (
      .clk(clk), .reset_n(reset_n), .init_iv(init_iv[g]), .iv(iv[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_block(in_block[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_block(out_block[g]),
      .busy(busy[g]), .dec_next(dec_next[g]), .dec_block(dec_block[g]),
      .dec_ready(dec_ready[g]), .dec_new_block(dec_new_block[g])
    );
    // Decipher stand-in: stays ready (with garbage data) for 1+early cycles, then busy for lat+1.
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dec_ready[g]     <= 1'b1;
        dec_new_block[g] <= '0;
        pend <= 1'b0;
        run  <= 1'b0;
        hold <= 0;
        cnt  <= 0;
        m_ct <= '0;
      end else if (dec_next[g]) begin
        npulse[g]        <= npulse[g] + 1;
        pend             <= 1'b1;
        hold             <= m_early[g];
        m_ct             <= dec_block[g];
        dec_new_block[g] <= rnd128();
      end else if (pend) begin
        if (hold != 0) hold <= hold - 1;
        else begin
          pend         <= 1'b0;
          run          <= 1'b1;
          dec_ready[g] <= 1'b0;
          cnt          <= m_lat[g];
        end
      end else if (run) begin
        if (cnt == 0) begin
          run              <= 1'b0;
          dec_ready[g]     <= 1'b1;
          dec_new_block[g] <= aes_dec(m_ct);
        end else cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_iv(input int i, input logic [127:0] v, input bit with_blk, input logic [127:0] ct);
    init_iv[i] = 1'b1;
    iv[i] = v;
    if (with_blk) begin
      in_valid[i] = 1'b1;
      in_block[i] = ct;
    end
    #1;
    chk("iv_in_ready_low", in_ready[i], 0);
    @(negedge clk);
    init_iv[i] = 1'b0;
    ref_chain[i] = v;
  endtask

  task automatic send(input int i, input logic [127:0] ct, input int bp);
    logic [127:0] exp;
    int n, p0;
    bit stable;
    exp = aes_dec(ct) ^ (i == 0 ? ref_chain[i] : 128'h0);
    ref_chain[i] = ct;
    m_lat[i]   = $urandom_range(1, 8);
    m_early[i] = $urandom_range(0, 2);
    in_valid[i] = 1'b1;
    in_block[i] = ct;
    #1;
    n = 0;
    while (!in_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready[i], 1);
    p0 = npulse[i];
    @(negedge clk);
    in_valid[i] = 1'b0;
    in_block[i] = rnd128();
    chk("dec_next_start", dec_next[i], 1);
    n = 1;
    stable = 1'b1;
    while (!out_valid[i] && n < 100) begin
      if (dec_block[i] !== ct || in_ready[i] !== 1'b0) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("latency", n, 5 + m_early[i] + m_lat[i]);
    chk("plaintext", out_block[i], exp);
    repeat (bp) begin
      if (out_block[i] !== exp || in_ready[i] !== 1'b0 || out_valid[i] !== 1'b1 || dec_block[i] !== ct)
        stable = 1'b0;
      in_valid[i] = 1'($urandom_range(0, 1));
      in_block[i] = rnd128();
      @(negedge clk);
    end
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    chk("held_stable", stable, 1);
    chk("out_valid_drop", out_valid[i], 0);
    chk("in_ready_back", in_ready[i], 1);
    chk("one_pulse", npulse[i] - p0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] v, c;
    int p0;
    for (int i = 0; i < 2; i++) begin
      init_iv[i] = 0; iv[i] = '0; in_valid[i] = 0; in_block[i] = '0; out_ready[i] = 0;
      m_lat[i] = 1; m_early[i] = 0; npulse[i] = 0; ref_chain[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", in_ready[i], 1);
      chk("rst_out_valid", out_valid[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_dec_next", dec_next[i], 0);
      chk("rst_dec_block", dec_block[i], 0);
      chk("rst_out_block", out_block[i], 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    // reset in the middle of WAIT abandons the block and clears the chain
    load_iv(0, rnd128(), 0, '0);
    m_lat[0] = 15; m_early[0] = 0;
    in_valid[0] = 1'b1; in_block[0] = rnd128();
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_wait_busy", busy[0], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready[0], 1);
    chk("arst_out_valid", out_valid[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_dec_block", dec_block[0], 0);
    p0 = npulse[0];
    ref_chain[0] = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) chk("arst_no_output", out_valid[0], 0);
    end
    chk("arst_no_repulse", npulse[0] - p0, 0);
    send(0, rnd128(), 0);
    // SP800-38A CBC vectors
    load_iv(0, 128'h000102030405060708090a0b0c0d0e0f, 0, '0);
    send(0, 128'h7649abac8119b246cee98e9b12e9197d, 1);
    chk("sp800_blk1", out_block[0], 128'h6bc1bee22e409f96e93d7e117393172a);
    send(0, 128'h5086cb9b507219ee95db113a917678b2, 0);
    chk("sp800_blk2", out_block[0], 128'hae2d8a571e03ac9c9eb76fac45af8e51);
    send(0, rnd128(), 20);
    // init_iv and in_valid together: IV wins, block taken next cycle with the new IV
    v = rnd128();
    c = rnd128();
    load_iv(0, v, 1, c);
    send(0, c, 0);
    chk("iv_same_cycle", out_block[0], aes_dec(c) ^ v);
    // ECB instance ignores the chaining value
    load_iv(1, rnd128(), 0, '0);
    send(1, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 2);
    chk("ecb_vector", out_block[1], 128'h6bc1bee22e409f96e93d7e117393172a);
    load_iv(1, rnd128(), 0, '0);
    send(1, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 0);
    chk("ecb_vector_iv2", out_block[1], 128'h6bc1bee22e409f96e93d7e117393172a);
    for (int k = 0; k < 24; k++) begin
      int i;
      i = k % 2;
      if ($urandom_range(0, 4) == 0) load_iv(i, rnd128(), 1'($urandom_range(0, 1)), rnd128());
      send(i, rnd128(), $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
